// File: rtl/quad_step_decoder.sv
// Quadrature front-end: 2-flop sync + per-channel glitch filter + Gray-code step/direction decode.
// Latency: input change sampled at edge k appears on phase/step/up_down at edge k+1+FILT_LEN.
// Backpressure: none; enable low suppresses step and freezes up_down while phase keeps tracking.
module quad_step_decoder #(
    parameter int FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       enable,
    input  logic       err_clr,
    output logic       step,
    output logic       up_down,
    output logic       err,
    output logic [1:0] phase
);

    typedef enum logic {SETTLE, TRACK} state_t;

    localparam logic [3:0] FC_MAX      = 4'(FILT_LEN - 1);
    localparam logic [4:0] SETTLE_LAST = 5'(FILT_LEN + 2);

    state_t     state, state_nxt;
    logic [4:0] settle_cnt, settle_cnt_nxt;
    logic       a_s1, a_s2, b_s1, b_s2;
    logic       a_f, b_f, a_f_nxt, b_f_nxt;
    logic [3:0] a_fc, b_fc, a_fc_nxt, b_fc_nxt;
    logic       step_nxt, up_down_nxt, err_nxt;
    logic [1:0] phase_nxt, phase_up;

    // Returns {f, fc} for the next cycle of one channel's filter.
    function automatic logic [4:0] filt_next(input logic s, input logic f, input logic [3:0] fc);
        logic [4:0] r;
        if (s == f)
            r = {f, 4'd0};
        else if (fc == FC_MAX)
            r = {s, 4'd0};
        else
            r = {f, fc + 4'd1};
        return r;
    endfunction

    assign phase     = {a_f, b_f};
    assign phase_nxt = {a_f_nxt, b_f_nxt};
    // Successor of the current phase along 00->10->11->01->00.
    assign phase_up  = {~b_f, a_f};

    always_comb begin
        state_nxt              = state;
        settle_cnt_nxt         = settle_cnt;
        {a_f_nxt, a_fc_nxt}    = filt_next(a_s2, a_f, a_fc);
        {b_f_nxt, b_fc_nxt}    = filt_next(b_s2, b_f, b_fc);
        step_nxt               = 1'b0;
        up_down_nxt            = up_down;
        err_nxt                = err & ~err_clr;
        case (state)
            SETTLE: begin
                a_f_nxt        = a_s2;
                b_f_nxt        = b_s2;
                a_fc_nxt       = 4'd0;
                b_fc_nxt       = 4'd0;
                settle_cnt_nxt = settle_cnt + 5'd1;
                if (settle_cnt == SETTLE_LAST)
                    state_nxt = TRACK;
            end
            TRACK: begin
                if ((phase ^ phase_nxt) == 2'b11) begin
                    err_nxt = 1'b1;
                end else if ((phase != phase_nxt) && enable) begin
                    step_nxt    = 1'b1;
                    up_down_nxt = (phase_nxt == phase_up);
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SETTLE;
            settle_cnt <= 5'd0;
            a_s1       <= 1'b0;
            a_s2       <= 1'b0;
            b_s1       <= 1'b0;
            b_s2       <= 1'b0;
            a_f        <= 1'b0;
            b_f        <= 1'b0;
            a_fc       <= 4'd0;
            b_fc       <= 4'd0;
            step       <= 1'b0;
            up_down    <= 1'b1;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            a_s1       <= a_in;
            a_s2       <= a_s1;
            b_s1       <= b_in;
            b_s2       <= b_s1;
            a_f        <= a_f_nxt;
            b_f        <= b_f_nxt;
            a_fc       <= a_fc_nxt;
            b_fc       <= b_fc_nxt;
            step       <= step_nxt;
            up_down    <= up_down_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: window-based behavioural model checked every cycle plus directed literal checks.
module tb_quad_step_decoder;

    localparam int FL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       enable = 1'b1;
    logic       err_clr = 1'b0;
    logic       step, up_down, err;
    logic [1:0] phase;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    quad_step_decoder #(.FILT_LEN(FL)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .enable(enable),
        .err_clr(err_clr), .step(step), .up_down(up_down), .err(err), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Input history per channel, newest first; entry j is the input sampled j edges ago.
    logic qa[$];
    logic qb[$];
    int   n;
    logic mfa, mfb, m_step, m_ud, m_err;

    function automatic int pos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        logic       nfa, nfb, mset;
        bit         alla, allb;
        logic [1:0] oldp, newp;
        if (!rst) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 20; i++) begin
                qa.push_back(1'b0);
                qb.push_back(1'b0);
            end
            n = 0; mfa = 0; mfb = 0; m_step = 0; m_ud = 1; m_err = 0;
        end else begin
            n++;
            mset = 1'b0;
            m_step = 1'b0;
            if (n <= FL + 3) begin
                nfa = qa[1];
                nfb = qb[1];
            end else begin
                // A level is accepted once the synchronised value disagreed with it for FL tracked samples in a row.
                alla = (n - (FL + 3)) >= FL;
                allb = alla;
                for (int j = 1; j <= FL; j++) begin
                    if (qa[j] == mfa) alla = 0;
                    if (qb[j] == mfb) allb = 0;
                end
                nfa = alla ? ~mfa : mfa;
                nfb = allb ? ~mfb : mfb;
                oldp = {mfa, mfb};
                newp = {nfa, nfb};
                if (newp != oldp) begin
                    if ((pos(newp) - pos(oldp) + 4) % 4 == 2)
                        mset = 1'b1;
                    else if (enable) begin
                        m_step = 1'b1;
                        m_ud   = (pos(newp) == (pos(oldp) + 1) % 4);
                    end
                end
            end
            if (mset) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            mfa = nfa;
            mfb = nfb;
            qa.push_front(a_in); void'(qa.pop_back());
            qb.push_front(b_in); void'(qb.pop_back());
        end
    end

    always @(negedge clk) begin
        if (check_en && rst) begin
            check("cyc_step", step, m_step);
            check("cyc_up_down", up_down, m_ud);
            check("cyc_err", err, m_err);
            check("cyc_phase", phase, {mfa, mfb});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic move(input logic [1:0] ab, input bit exp_step, input logic exp_ud, input string nm);
        int pulses = 0;
        @(negedge clk);
        a_in = ab[1];
        b_in = ab[0];
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (step) pulses++;
            if (i >= 4 && i <= 6)
                check($sformatf("%s_step_edge%0d", nm, i), step, (i == 5) && exp_step);
            if (i == 5 && exp_step)
                check($sformatf("%s_up_down", nm), up_down, exp_ud);
        end
        check($sformatf("%s_pulses", nm), pulses, exp_step);
        check($sformatf("%s_phase", nm), phase, ab);
    endtask

    task automatic idle_count(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (step) pulses++;
        end
    endtask

    initial begin
        int p;
        // Reset and settle with both channels high
        a_in = 1; b_in = 1;
        #3 rst = 0;
        #1;
        check("rst_step", step, 0);
        check("rst_up_down", up_down, 1);
        check("rst_err", err, 0);
        check("rst_phase", phase, 0);
        check_en = 1'b1;
        @(negedge clk); #2 rst = 1;
        idle_count(10, p);
        check("settle_pulses", p, 0);
        check("settle_phase", phase, 3);
        check("settle_model_phase", {mfa, mfb}, 3);
        check("settle_err", err, 0);
        check("settle_up_down", up_down, 1);

        // Reset in the middle of a pending filter mismatch
        @(negedge clk); a_in = 0;
        idle_count(3, p);
        #2 rst = 0; b_in = 0;
        #1;
        check("midrst_phase", phase, 0);
        check("midrst_step", step, 0);
        check("midrst_err", err, 0);
        @(negedge clk); #2 rst = 1;
        idle_count(10, p);
        check("midrst_pulses", p, 0);
        check("midrst_settled_phase", phase, 0);

        // Down sequence from 00
        move(2'b01, 1, 0, "dn1");
        move(2'b11, 1, 0, "dn2");
        move(2'b10, 1, 0, "dn3");
        move(2'b00, 1, 0, "dn4");

        // Glitch on a_in lasting two samples
        @(negedge clk); a_in = 1;
        @(negedge clk);
        @(negedge clk); a_in = 0;
        idle_count(10, p);
        check("glitch_pulses", p, 0);
        check("glitch_phase", phase, 0);

        // Up sequence from 00
        move(2'b10, 1, 1, "up1");
        move(2'b11, 1, 1, "up2");
        move(2'b01, 1, 1, "up3");
        move(2'b00, 1, 1, "up4");

        // Enable gating
        @(negedge clk); enable = 0;
        move(2'b10, 0, 1, "gated_up");
        check("gated_up_down", up_down, 1);
        @(negedge clk); enable = 1;
        move(2'b00, 1, 0, "reen_down");

        // Illegal move, clear, and set-over-clear priority
        move(2'b11, 0, 1, "illegal1");
        check("illegal1_err", err, 1);
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0;
        check("err_cleared", err, 0);
        @(negedge clk); a_in = 0; b_in = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check("illegal2_err_before", err, 0);
                err_clr = 1;
            end
            if (i == 5) begin
                err_clr = 0;
                check("illegal2_err_set_wins", err, 1);
                check("illegal2_step", step, 0);
            end
        end
        check("illegal2_phase", phase, 0);
        check("illegal2_up_down", up_down, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
